// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for serial_subtractor.
// Optional `sub` select exists only when ADDSUB_MODE_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDSUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
`ifdef ADDSUB_MODE_EN
    output sub,
`endif
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
`ifdef ADDSUB_MODE_EN
    input  sub,
`endif
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell iterated over WIDTH cycles.
// ADDSUB_MODE_EN adds a captured `sub` select (0 = add, borrow carries carry-out).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bff_q, bff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sub_q;
  logic             ai, bi, cell_d, cell_out;

`ifdef ADDSUB_MODE_EN
  logic sub_d;
`else
  assign sub_q = 1'b1;
`endif

  // Full-subtractor / full-adder cell on the current LSBs
  always_comb begin
    ai     = a_sr_q[0];
    bi     = b_sr_q[0];
    cell_d = ai ^ bi ^ bff_q;
    if (sub_q) cell_out = (~ai & bi) | (~(ai ^ bi) & bff_q);
    else       cell_out = (ai & bi) | (bff_q & (ai ^ bi));
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bff_d    = bff_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef ADDSUB_MODE_EN
    sub_d    = sub_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // Accept from IDLE or back-to-back from DONE
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          bff_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef ADDSUB_MODE_EN
          sub_d   = bus.sub;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        d_sr_d = {cell_d, d_sr_q[WIDTH-1:1]};
        bff_d  = cell_out;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = {cell_d, d_sr_q[WIDTH-1:1]};
          borrow_d = cell_out;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bff_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADDSUB_MODE_EN
      sub_q    <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bff_q    <= bff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ADDSUB_MODE_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus randomized ops
// against an arithmetic reference model. Exercises ADDSUB_MODE_EN when defined.
module tb_serial_subtractor;
  localparam int unsigned WIDTH = 8;
  localparam int          LIMIT = 40;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] prev_diff;
  logic             prev_borrow;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic; result = {borrow/carry, diff}
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sub);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r;
    if (sub) begin
      r = (ua - ub) & ((1 << WIDTH) - 1);
      return {(ua < ub) ? 1'b1 : 1'b0, WIDTH'(r)};
    end
    r = ua + ub;
    return {(r >= (1 << WIDTH)) ? 1'b1 : 1'b0, WIDTH'(r)};
  endfunction

  // Counts negedges until done; tracks busy cycles and output stability before done
  task automatic wait_done(output int n, output int busy_n, output bit stable);
    n = 0; busy_n = 0; stable = 1'b1;
    while (n < LIMIT) begin
      @(negedge clk);
      n++;
      if (bus.done) break;
      if (bus.busy) busy_n++;
      if (bus.diff !== prev_diff || bus.borrow !== prev_borrow) stable = 1'b0;
    end
    if (!bus.done) n = -1;
  endtask

  task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
`ifdef ADDSUB_MODE_EN
    bus.sub   = sub;
`else
    if (sub) bus.start = 1'b1;
`endif
  endtask

  // One full operation from a negedge; optionally scrambles inputs after acceptance
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sub, input bit scramble);
    logic [WIDTH:0] exp;
    int n, bn;
    bit st;
    exp = model(a, b, sub);
    drive_start(a, b, sub);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
`ifdef ADDSUB_MODE_EN
      bus.sub = ~sub;
`endif
    end
    wait_done(n, bn, st);
    check({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
    check({tag, "_busy"}, 32'(bn), 32'(WIDTH));
    check({tag, "_held"}, 32'(st), 32'd1);
    check({tag, "_diff"}, 32'(bus.diff), 32'(exp[WIDTH-1:0]));
    check({tag, "_borrow"}, 32'(bus.borrow), 32'(exp[WIDTH]));
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    check({tag, "_diff_hold"}, 32'(bus.diff), 32'(exp[WIDTH-1:0]));
    prev_diff   = exp[WIDTH-1:0];
    prev_borrow = exp[WIDTH];
  endtask

  initial begin
    int n, bn;
    bit st;
    logic [WIDTH:0] exp;
    logic [WIDTH-1:0] ra, rb;
    logic rs;

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef ADDSUB_MODE_EN
    bus.sub = 1'b1;
`endif
    prev_diff = '0;
    prev_borrow = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 8'h05, 8'h03, 1'b1, 1'b0);
    run_op("t2a", 8'h03, 8'h05, 1'b1, 1'b0);
    run_op("t2b", 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("t4", 8'hFF, 8'h0F, 1'b1, 1'b1);

    // Back-to-back with start held high
    exp = model(8'h80, 8'h01, 1'b1);
    drive_start(8'h80, 8'h01, 1'b1);
    @(posedge clk);
    wait_done(n, bn, st);
    check("b2b0_diff", 32'(bus.diff), 32'(exp[WIDTH-1:0]));
    prev_diff = exp[WIDTH-1:0];
    prev_borrow = exp[WIDTH];
    for (int i = 0; i < 3; i++) begin
      wait_done(n, bn, st);
      check("b2b_gap", 32'(n), 32'(WIDTH + 1));
      check("b2b_busy", 32'(bn), 32'(WIDTH));
      check("b2b_diff", 32'(bus.diff), 32'(exp[WIDTH-1:0]));
      check("b2b_borrow", 32'(bus.borrow), 32'(exp[WIDTH]));
    end
    bus.start = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of SHIFT
    drive_start(8'h5A, 8'h21, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_borrow", 32'(bus.borrow), 32'd0);
    rst_n = 1'b1;
    prev_diff = '0;
    prev_borrow = 1'b0;
    @(negedge clk);
    run_op("t5", 8'h3C, 8'h0A, 1'b1, 1'b0);

`ifdef ADDSUB_MODE_EN
    run_op("t6add", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("t6sub", 8'hFF, 8'h01, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
`ifdef ADDSUB_MODE_EN
      rs = 1'($urandom);
`else
      rs = 1'b1;
`endif
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; end
      if (i == 1) begin ra = 8'hFF; rb = 8'hFF; end
      run_op("rnd", ra, rb, rs, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
